up_down_counter_seq: RTL and testbench

//  Command-side driver for the 4-bit up/down counter. It accepts a target count over a

---
 rtl/up_down_counter_seq.sv | 174 +++++++++++++++++
 tb/tb_up_down_counter_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_seq.sv
// ---------------------------------------------------------------------------
// up_down_counter_seq
//
// Command-side driver for a WIDTH-bit up/down counter. A target count is
// accepted over a valid/ready handshake. The block then drives the counter's
// {s0,s1}/x command stream along the shortest wrap-around path to the target.
// That path is either a short run of single steps up or down, or one direct
// load. The block keeps a mirror of the count the counter should hold. When
// the sequence completes, it compares the mirror with the counter's y output
// and raises a sticky error flag on any difference.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   res         synchronous active-low reset
//   req_valid   target request valid (only looked at while idle)
//   req_ready   high while idle
//   req_target  requested count, captured on the handshake
//   cnt_y       counter y output, compared with the mirror in DONE
//   s0, s1      registered counter command: 00 load, 01 up, 10 down, 11 hold
//   x           registered counter load value, holds when not loading
//   busy        high whenever a request is in flight
//   done        one-cycle pulse when the target has been reached
//   err         sticky mismatch flag, cleared only by reset
//   mirror      internal copy of the expected counter value
// ---------------------------------------------------------------------------
module up_down_counter_seq #(
    parameter int WIDTH     = 4,
    parameter int MAX_STEPS = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] cnt_y,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mirror
);

    localparam logic [WIDTH-1:0] MAX_DIST = WIDTH'(MAX_STEPS);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        LOAD,
        STEP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] rem;
    logic             dir;
    logic             dir_next;
    logic [1:0]       cmd_next;
    logic [WIDTH-1:0] up_dist;
    logic [WIDTH-1:0] dn_dist;
    logic [WIDTH-1:0] min_dist;

    // Wrap-around distances in both directions. The subtraction is naturally
    // modulo 2^WIDTH. On a tie, stepping up is preferred.
    always_comb begin
        up_dist  = tgt - mirror;
        dn_dist  = mirror - tgt;
        min_dist = (up_dist <= dn_dist) ? up_dist : dn_dist;
    end

    // Next-state and next-command logic. The command outputs are registered,
    // so the code is chosen from the state being entered. That way the
    // command is visible for the whole LOAD or STEP cycle it belongs to.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        cmd_next   = 2'b11;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = PLAN;
                end
            end
            PLAN: begin
                if (up_dist == '0) begin
                    state_next = DONE;
                end else if (min_dist > MAX_DIST) begin
                    state_next = LOAD;
                end else begin
                    state_next = STEP;
                    dir_next   = (up_dist <= dn_dist);
                end
            end
            LOAD: begin
                state_next = DONE;
            end
            STEP: begin
                if (rem == ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            LOAD:    cmd_next = 2'b00;
            STEP:    cmd_next = dir_next ? 2'b01 : 2'b10;
            default: cmd_next = 2'b11;
        endcase
    end

    // State, command registers and mirror bookkeeping. The mirror is updated
    // on the same edge that the counter applies a command. As a result, by
    // DONE both the mirror and cnt_y reflect the final command.
    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= IDLE;
            {s0, s1}   <= 2'b11;
            x          <= '0;
            err        <= 1'b0;
            mirror     <= '0;
            tgt        <= '0;
            rem        <= '0;
            dir        <= 1'b0;
        end else begin
            state    <= state_next;
            {s0, s1} <= cmd_next;
            dir      <= dir_next;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt <= req_target;
                    end
                end
                PLAN: begin
                    rem <= min_dist;
                    if (state_next == LOAD) begin
                        x <= tgt;
                    end
                end
                LOAD: begin
                    mirror <= tgt;
                end
                STEP: begin
                    mirror <= dir ? (mirror + ONE) : (mirror - ONE);
                    rem    <= rem - ONE;
                end
                DONE: begin
                    if (cnt_y != mirror) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_up_down_counter_seq.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_seq
//
// Directed bench for up_down_counter_seq. A small behavioural model of the
// 4-bit up/down counter consumes the DUT's command stream and feeds cnt_y
// back. That feedback can be deliberately corrupted to provoke the sticky
// error flag. Inputs are driven and outputs sampled on the falling edge.
// Expected command codes, cycle counts and values are hand-computed per step.
// Latency is counted from the accepting cycle, taken as cycle 0: done
// appears in cycle 2 with no move, in cycle 3 for a load, and in cycle
// 2+rem when stepping.
// ---------------------------------------------------------------------------
module tb_up_down_counter_seq;

    logic       clk;
    logic       res;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_target;
    logic [3:0] cnt_y;
    logic       s0;
    logic       s1;
    logic [3:0] x;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] mirror;

    logic [3:0] cnt_model;
    logic       corrupt;
    logic       err_exp;
    int         tests_run;
    int         tests_failed;

    up_down_counter_seq #(
        .WIDTH     (4),
        .MAX_STEPS (3)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .cnt_y      (cnt_y),
        .s0         (s0),
        .s1         (s1),
        .x          (x),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mirror     (mirror)
    );

    always #5 clk = ~clk;

    // Behavioural counter: load, up, down or hold on each rising edge.
    always @(posedge clk) begin
        if (!res) begin
            cnt_model <= 4'd0;
        end else begin
            case ({s0, s1})
                2'b00:   cnt_model <= x;
                2'b01:   cnt_model <= cnt_model + 4'd1;
                2'b10:   cnt_model <= cnt_model - 4'd1;
                default: cnt_model <= cnt_model;
            endcase
        end
    end

    assign cnt_y = corrupt ? (cnt_model + 4'd1) : cnt_model;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One request: present the target, then check the PLAN cycle, then check
    // n_cmd cycles of exp_cmd, then check the done cycle and the return to
    // idle. With hold set, req_valid stays high until the done cycle.
    task automatic applyStimulus(input string name, input logic [3:0] target,
                                 input logic [1:0] exp_cmd, input int n_cmd,
                                 input logic [3:0] exp_x, input logic hold);
        req_valid  = 1'b1;
        req_target = target;
        checkOutput({name, " ready before accept"}, int'(req_ready), 1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        checkOutput({name, " plan cmd"}, int'({s0, s1}), 3);
        checkOutput({name, " plan busy"}, int'(busy), 1);
        checkOutput({name, " plan ready"}, int'(req_ready), 0);
        for (int i = 0; i < n_cmd; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s cmd cycle %0d", name, i), int'({s0, s1}), int'(exp_cmd));
            checkOutput($sformatf("%s no done cycle %0d", name, i), int'(done), 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput({name, " done pulse"}, int'(done), 1);
        checkOutput({name, " done cmd"}, int'({s0, s1}), 3);
        checkOutput({name, " mirror"}, int'(mirror), int'(target));
        checkOutput({name, " counter y"}, int'(cnt_model), int'(target));
        checkOutput({name, " x"}, int'(x), int'(exp_x));
        checkOutput({name, " err at done"}, int'(err), int'(err_exp));
        @(negedge clk);
        checkOutput({name, " back to idle"}, int'(req_ready), 1);
        checkOutput({name, " busy low"}, int'(busy), 0);
        checkOutput({name, " done low"}, int'(done), 0);
    endtask

    initial begin
        clk          = 1'b0;
        res          = 1'b0;
        req_valid    = 1'b0;
        req_target   = 4'd0;
        corrupt      = 1'b0;
        err_exp      = 1'b0;
        tests_run    = 0;
        tests_failed = 0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset cmd", int'({s0, s1}), 3);
        checkOutput("reset x", int'(x), 0);
        checkOutput("reset ready", int'(req_ready), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset err", int'(err), 0);
        checkOutput("reset mirror", int'(mirror), 0);
        res = 1'b1;
        @(negedge clk);

        // 0 -> 3: three up steps
        applyStimulus("t1 up3", 4'd3, 2'b01, 3, 4'd0, 1'b0);
        // 3 -> 1: two down steps
        applyStimulus("t2 dn2", 4'd1, 2'b10, 2, 4'd0, 1'b0);
        // 1 -> 15: two down steps wrapping through 0, no load
        applyStimulus("t3 wrap", 4'd15, 2'b10, 2, 4'd0, 1'b0);
        // 15 -> 7: distance 8 both ways, single load
        applyStimulus("t4 load", 4'd7, 2'b00, 1, 4'd7, 1'b0);
        // 7 -> 7: no move, req_valid held while busy
        applyStimulus("t5 nomove", 4'd7, 2'b11, 0, 4'd7, 1'b1);
        @(negedge clk);
        checkOutput("t5 no re-accept busy", int'(busy), 0);

        // Reset in the middle of a 3-step run toward 10
        req_valid  = 1'b1;
        req_target = 4'd10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6 first step cmd", int'({s0, s1}), 1);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        checkOutput("t6 abort cmd", int'({s0, s1}), 3);
        checkOutput("t6 abort x", int'(x), 0);
        checkOutput("t6 abort mirror", int'(mirror), 0);
        checkOutput("t6 abort ready", int'(req_ready), 1);
        checkOutput("t6 abort busy", int'(busy), 0);

        // Corrupted cnt_y at DONE sets err, which then sticks
        corrupt = 1'b1;
        applyStimulus("t7 corrupt", 4'd2, 2'b01, 2, 4'd0, 1'b0);
        corrupt = 1'b0;
        err_exp = 1'b1;
        checkOutput("t7 err set", int'(err), 1);
        applyStimulus("t8 sticky", 4'd2, 2'b11, 0, 4'd0, 1'b0);
        checkOutput("t8 err still set", int'(err), 1);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        checkOutput("t8 err cleared by reset", int'(err), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
